// File: rtl/equiv_sweep_ctrl_pkg.sv
// Shared definitions for the equivalence sweep controller: the FSM state encoding
// and the vector-count derivation.
package equiv_sweep_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic int calc_nvec(input int n_in);
        return 32'sd1 <<< n_in;
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that times the settle interval between applying a
// vector and sampling the implementations.
module sweep_settle_timer #(
    parameter  int CNT_INIT = 1,
    localparam int CW       = $clog2(CNT_INIT + 2)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expired
);

    logic [CW-1:0] r_cnt;

    // Down-counter: load the settle length, then count towards zero
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= CW'(CNT_INIT);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // The counter holds the remaining cycles including the current one,
    // so a value of 1 marks the last settle cycle.
    assign expired = (r_cnt <= CW'(1));

endmodule

// File: rtl/equiv_sweep_ctrl.sv
// Sweeps every input vector through three implementations of one boolean
// function, counts disagreements, records the first failure and captures tt_c.
module equiv_sweep_ctrl
    import equiv_sweep_ctrl_pkg::*;
#(
    parameter  int N_IN   = 2,
    parameter  int SETTLE = 1,
    localparam int NVEC   = calc_nvec(N_IN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic [N_IN-1:0] x,
    input  logic            dut_a,
    input  logic            dut_b,
    input  logic            dut_c,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail,
    output logic [NVEC-1:0] tt_c
);

    state_t          r_state;
    state_t          w_next_state;
    logic [N_IN-1:0] r_vec;
    logic [N_IN-1:0] r_x;
    logic [N_IN-1:0] r_first_fail;
    logic [N_IN:0]   r_err_count;
    logic [N_IN:0]   w_err_next;
    logic [NVEC-1:0] r_tt_c;
    logic            r_busy;
    logic            r_done;
    logic            r_pass;
    logic            r_fail_valid;
    logic            w_sweep_start;
    logic            w_timer_load;
    logic            w_timer_expired;
    logic            w_mismatch;
    logic            w_last_vec;

    sweep_settle_timer #(
        .CNT_INIT (SETTLE)
    ) u_settle_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (w_timer_load),
        .expired (w_timer_expired)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next_state = ST_APPLY;
                end else begin
                    w_next_state = r_state;
                end
            end
            ST_APPLY: begin
                if (SETTLE > 0) begin
                    w_next_state = ST_SETTLE;
                end else begin
                    w_next_state = ST_CHECK;
                end
            end
            ST_SETTLE: begin
                if (w_timer_expired) begin
                    w_next_state = ST_CHECK;
                end else begin
                    w_next_state = ST_SETTLE;
                end
            end
            ST_CHECK: begin
                if (w_last_vec) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_APPLY;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Per-state control and compare decode
    always_comb begin
        w_sweep_start = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
        w_timer_load  = (r_state == ST_APPLY);
        w_mismatch    = !((dut_a == dut_b) && (dut_b == dut_c));
        w_last_vec    = (r_vec == N_IN'(NVEC - 1));
        w_err_next    = r_err_count + {{N_IN{1'b0}}, w_mismatch};
    end

    // Vector counter, drive register and sweep result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vec        <= '0;
            r_x          <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_first_fail <= '0;
            r_tt_c       <= '0;
        end else begin
            r_busy <= (w_next_state == ST_APPLY) || (w_next_state == ST_SETTLE) ||
                      (w_next_state == ST_CHECK);
            r_done <= (w_next_state == ST_DONE);
            if (w_sweep_start) begin
                r_vec        <= '0;
                r_pass       <= 1'b0;
                r_err_count  <= '0;
                r_fail_valid <= 1'b0;
                r_first_fail <= '0;
                r_tt_c       <= '0;
            end else if (r_state == ST_APPLY) begin
                r_x <= r_vec;
            end else if (r_state == ST_CHECK) begin
                r_tt_c[r_vec] <= dut_c;
                r_err_count   <= w_err_next;
                if (w_mismatch && !r_fail_valid) begin
                    r_fail_valid <= 1'b1;
                    r_first_fail <= r_vec;
                end
                // pass reflects the count including this final compare
                if (w_last_vec) begin
                    r_pass <= (w_err_next == '0);
                end else begin
                    r_vec <= r_vec + N_IN'(1);
                end
            end
        end
    end

    assign x          = r_x;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign fail_valid = r_fail_valid;
    assign first_fail = r_first_fail;
    assign tt_c       = r_tt_c;

endmodule
